serial_sub_ctrl: RTL and testbench
==================================

Name: serial_sub_ctrl

Overview:
- Bit-serial subtractor controller. Sequences a single one-bit full-subtractor cell (d = x^y^bi; bo = (~x&y)|(~(x^y)&bi)) over WIDTH clock cycles, LSB first.
- Computes diff = a - b - bin and the final borrow.
- Sits between a requester issuing start/operands and downstream logic consuming the done/diff result. Trades area for latency relative to a parallel ripple subtractor.

Parameters:
- WIDTH, 8, operand/result width in bits (>=1).

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, request; sampled only in IDLE.
- a, input, WIDTH, minuend; captured on accepted start.
- b, input, WIDTH, subtrahend; captured on accepted start.
- bin, input, 1, initial borrow-in; captured on accepted start.
- busy, output, 1, high in RUN and DONE.
- done, output, 1, one-cycle pulse; result valid from this cycle on.
- diff, output, WIDTH, registered difference, held until the next result.
- bout, output, 1, final borrow-out (1 = unsigned a < b+bin).
- ovf, output, 1, signed overflow of a-b-bin in two's complement.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy=0, done=0, diff=0, bout=0, ovf=0; shift registers, borrow flop and bit counter cleared.
- IDLE:
  - On a clk edge with start=1: load a into shift reg SA, b into SB, bin into borrow flop BR, counter=0, clear diff shift reg SD; go to RUN.
  - start=0: stay in IDLE.
- RUN, on each edge:
  - Apply the full-subtractor cell to SA[0], SB[0], BR.
  - Shift the d bit into SD from the MSB side; shift SA/SB right by one.
  - BR <= bo; counter++.
  - When counter reaches WIDTH-1 on this edge (last bit), go to DONE. The same edge loads diff <= final SD, bout <= final bo, ovf <= (a_msb != b_msb) && (diff_msb != a_msb), using the captured operand MSBs.
- DONE: done=1, busy=1 for exactly one cycle; next edge goes to IDLE unconditionally.
- Latency: start sampled at edge E0 gives done high in the cycle after edge E0+WIDTH. That is WIDTH+1 cycles from the accept edge, and the throughput is one operation per WIDTH+2 cycles.
- Outputs diff/bout/ovf change only on the edge entering DONE (or on reset). They hold stable through IDLE and the next RUN.
- start while busy (RUN or DONE): ignored, not queued. start held high continuously causes a new accept on the first IDLE edge after DONE.
- a/b/bin changes after the accept edge have no effect on the operation in flight.
- Reset mid-RUN aborts immediately. All outputs return to reset values and the partial result is discarded.
- WIDTH=1: RUN lasts one edge, so it behaves as a registered full subtractor.
- Arithmetic: modulo 2^WIDTH. bout equals the borrow out of the MSB cell, i.e. (a < b+bin) in unsigned terms.

Test Plan:
- WIDTH=8: a=100, b=37, bin=0, start pulsed at edge 0 -> busy rises. done pulses in the cycle after edge 8 with diff=63, bout=0, ovf=0. busy low after edge 9.
- a=5, b=9, bin=0 -> diff=0xFC, bout=1, ovf=0. Separately a=0, b=0, bin=1 -> diff=0xFF, bout=1, ovf=0.
- Overflow: a=0x80, b=0x01, bin=0 -> diff=0x7F, bout=0, ovf=1. Then a=0x7F, b=0xFF, bin=0 -> diff=0x80, bout=1, ovf=1.
- Protocol:
  - Assert start again at edge 3 of a running op with different operands -> ignored; the first result is unchanged.
  - Hold start=1 across DONE -> second op is accepted at the IDLE edge and its done arrives WIDTH+2 cycles after the first done.
  - Operand bus changes mid-RUN -> no effect.
- Reset: drive rst_n=0 asynchronously mid-RUN (between edges) -> busy/done/diff/bout/ovf drop to 0 immediately. After release, a fresh start gives a correct result.
- Exhaustive: WIDTH=1 and WIDTH=3, all a/b/bin combinations -> diff and bout match a-b-bin mod 2^WIDTH and the 8-row full-subtractor truth table. Results are held stable between operations.

Source files
------------

// File: rtl/serial_sub_ctrl.sv
// ---------------------------------------------------------------------------
// serial_sub_ctrl
//
// Bit-serial subtractor controller. A single one-bit full-subtractor cell is
// stepped over the operands LSB first, one bit per clock, and produces
// diff = a - b - bin (mod 2^WIDTH), the final borrow and the signed overflow.
// The design uses one cell and some shift registers in place of a WIDTH-bit
// ripple subtractor, so each result takes WIDTH+1 cycles to appear.
//
// Ports:
//    clk    in   rising-edge clock
//    rst_n  in   asynchronous active-low reset
//    start  in   operation request, sampled only while idle
//    a      in   [WIDTH] minuend, captured on the accepting edge
//    b      in   [WIDTH] subtrahend, captured on the accepting edge
//    bin    in   initial borrow-in, captured on the accepting edge
//    busy   out  high while an operation is running or finishing (RUN/DONE)
//    done   out  one-cycle pulse; diff/bout/ovf are valid from this cycle on
//    diff   out  [WIDTH] registered difference, held until the next result
//    bout   out  final borrow-out (1 = unsigned a < b + bin)
//    ovf    out  two's-complement overflow of a - b - bin
//
// Timing: start accepted at edge E0 -> WIDTH RUN edges (E0+1 .. E0+WIDTH)
// -> done high in the cycle after E0+WIDTH -> back to IDLE at E0+WIDTH+1.
// With start held high the next operation is accepted at E0+WIDTH+2.
// ---------------------------------------------------------------------------
module serial_sub_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf
);

   // Bit counter must be able to hold WIDTH-1; keep it at least one bit wide
   // so WIDTH=1 still elaborates cleanly.
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // ------------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------------
   logic [1:0]       state_reg, state_next;
   logic [WIDTH-1:0] sa_reg,    sa_next;     // minuend shift register
   logic [WIDTH-1:0] sb_reg,    sb_next;     // subtrahend shift register
   logic [WIDTH-1:0] sd_reg,    sd_next;     // partial difference, fills from MSB
   logic             br_reg,    br_next;     // running borrow between bit slices
   logic [CW-1:0]    cnt_reg,   cnt_next;    // index of the bit being processed
   logic             a_msb_reg, a_msb_next;  // operand sign bits for overflow
   logic             b_msb_reg, b_msb_next;
   logic [WIDTH-1:0] diff_reg,  diff_next;
   logic             bout_reg,  bout_next;
   logic             ovf_reg,   ovf_next;

   // ------------------------------------------------------------------------
   // The single full-subtractor cell, always looking at the current LSBs
   // ------------------------------------------------------------------------
   logic cell_x;
   logic cell_y;
   logic cell_d;
   logic cell_bo;

   assign cell_x  = sa_reg[0];
   assign cell_y  = sb_reg[0];
   assign cell_d  = cell_x ^ cell_y ^ br_reg;
   assign cell_bo = (~cell_x & cell_y) | (~(cell_x ^ cell_y) & br_reg);

   // Partial difference after inserting the new bit at the MSB end. After
   // WIDTH insertions the first (LSB) result bit has reached position 0.
   logic [WIDTH-1:0] sd_shift;

   generate
      if (WIDTH == 1) begin : g_sd_one
         assign sd_shift = cell_d;
      end else begin : g_sd_many
         assign sd_shift = {cell_d, sd_reg[WIDTH-1:1]};
      end
   endgenerate

   logic last_bit;
   logic ovf_calc;

   assign last_bit = (cnt_reg == LAST_BIT);

   // Subtraction overflows only when the operand signs differ and the
   // result sign disagrees with the minuend. On the last bit cell_d is the
   // result MSB. A borrow-in cannot cause overflow when the signs match,
   // because a - b then lies strictly inside the signed range.
   assign ovf_calc = (a_msb_reg != b_msb_reg) && (cell_d != a_msb_reg);

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      sa_next    = sa_reg;
      sb_next    = sb_reg;
      sd_next    = sd_reg;
      br_next    = br_reg;
      cnt_next   = cnt_reg;
      a_msb_next = a_msb_reg;
      b_msb_next = b_msb_reg;
      diff_next  = diff_reg;
      bout_next  = bout_reg;
      ovf_next   = ovf_reg;

      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               state_next = ST_RUN;
               sa_next    = a;
               sb_next    = b;
               br_next    = bin;
               cnt_next   = '0;
               sd_next    = '0;
               a_msb_next = a[WIDTH-1];
               b_msb_next = b[WIDTH-1];
            end
         end

         ST_RUN: begin
            sa_next  = sa_reg >> 1;
            sb_next  = sb_reg >> 1;
            sd_next  = sd_shift;
            br_next  = cell_bo;
            cnt_next = cnt_reg + CW'(1);
            if (last_bit) begin
               // The published outputs change only on this edge, so the
               // previous result stays visible through IDLE and most of RUN.
               state_next = ST_DONE;
               diff_next  = sd_shift;
               bout_next  = cell_bo;
               ovf_next   = ovf_calc;
            end
         end

         ST_DONE: begin
            // start is ignored here; a held request is taken in IDLE.
            state_next = ST_IDLE;
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Registers (asynchronous reset aborts any operation in flight)
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
         sa_reg    <= '0;
         sb_reg    <= '0;
         sd_reg    <= '0;
         br_reg    <= 1'b0;
         cnt_reg   <= '0;
         a_msb_reg <= 1'b0;
         b_msb_reg <= 1'b0;
         diff_reg  <= '0;
         bout_reg  <= 1'b0;
         ovf_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         sa_reg    <= sa_next;
         sb_reg    <= sb_next;
         sd_reg    <= sd_next;
         br_reg    <= br_next;
         cnt_reg   <= cnt_next;
         a_msb_reg <= a_msb_next;
         b_msb_reg <= b_msb_next;
         diff_reg  <= diff_next;
         bout_reg  <= bout_next;
         ovf_reg   <= ovf_next;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign busy = (state_reg != ST_IDLE);
   assign done = (state_reg == ST_DONE);
   assign diff = diff_reg;
   assign bout = bout_reg;
   assign ovf  = ovf_reg;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_sub_ctrl
//
// Self-checking bench for serial_sub_ctrl. Three instances (WIDTH = 8, 3, 1)
// share clk and rst_n. The expected results come from a behavioural model
// that does integer arithmetic on a - b - bin.
// ---------------------------------------------------------------------------
module tb_serial_sub_ctrl;

   logic clk;
   logic rst_n;

   logic       start8, bin8, busy8, done8, bout8, ovf8;
   logic [7:0] a8, b8, diff8;
   logic       start3, bin3, busy3, done3, bout3, ovf3;
   logic [2:0] a3, b3, diff3;
   logic       start1, bin1, busy1, done1, bout1, ovf1;
   logic [0:0] a1, b1, diff1;

   int n_err;
   int n_checks;
   int prev[9];   // last result per width, to check that outputs are held

   serial_sub_ctrl #(.WIDTH(8)) u_w8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
      .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .ovf(ovf8));

   serial_sub_ctrl #(.WIDTH(3)) u_w3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3), .bin(bin3),
      .busy(busy3), .done(done3), .diff(diff3), .bout(bout3), .ovf(ovf3));

   serial_sub_ctrl #(.WIDTH(1)) u_w1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .bin(bin1),
      .busy(busy1), .done(done1), .diff(diff1), .bout(bout1), .ovf(ovf1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural reference model ----------------
   function automatic void model(input int w, input int av, input int bv,
                                 input int bi, output int d, output int bo,
                                 output int ov);
      int m;
      int sa;
      int sb;
      int r;
      m  = 1 << w;
      d  = (av - bv - bi + 2 * m) % m;
      bo = (av < bv + bi) ? 1 : 0;
      sa = (av >= m / 2) ? av - m : av;
      sb = (bv >= m / 2) ? bv - m : bv;
      r  = sa - sb - bi;
      ov = (r < -(m / 2) || r > (m / 2 - 1)) ? 1 : 0;
   endfunction

   // ---------------- helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input int expv);
      n_checks++;
      assert (obs === 32'(expv))
      else begin
         n_err++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // sel: 0 busy, 1 done, 2 diff, 3 bout, 4 ovf
   function automatic logic [31:0] outp(input int w, input int sel);
      logic [31:0] r;
      r = '0;
      case (w)
         8: case (sel)
               0: r = 32'(busy8);  1: r = 32'(done8);  2: r = 32'(diff8);
               3: r = 32'(bout8);  default: r = 32'(ovf8);
            endcase
         3: case (sel)
               0: r = 32'(busy3);  1: r = 32'(done3);  2: r = 32'(diff3);
               3: r = 32'(bout3);  default: r = 32'(ovf3);
            endcase
         default: case (sel)
               0: r = 32'(busy1);  1: r = 32'(done1);  2: r = 32'(diff1);
               3: r = 32'(bout1);  default: r = 32'(ovf1);
            endcase
      endcase
      return r;
   endfunction

   task automatic drive(input int w, input int av, input int bv, input int bi,
                        input logic st);
      case (w)
         8: begin a8 = 8'(av); b8 = 8'(bv); bin8 = 1'(bi); start8 = st; end
         3: begin a3 = 3'(av); b3 = 3'(bv); bin3 = 1'(bi); start3 = st; end
         default: begin a1 = 1'(av); b1 = 1'(bv); bin1 = 1'(bi); start1 = st; end
      endcase
   endtask

   // One complete operation: accept, run, check result, return to idle.
   // disturb=1 scrambles the operand bus each RUN cycle and re-requests
   // start at the third RUN edge; neither may affect the result.
   task automatic run_op(input int w, input int av, input int bv, input int bi,
                         input bit disturb);
      int ed, eb, eo, k, lat;
      model(w, av, bv, bi, ed, eb, eo);
      drive(w, av, bv, bi, 1'b1);
      tick();
      drive(w, int'($urandom), int'($urandom), int'($urandom_range(1)), 1'b0);
      chk($sformatf("w%0d busy_after_accept", w), outp(w, 0), 1);
      chk($sformatf("w%0d diff_held_in_run", w), outp(w, 2), prev[w]);
      lat = -1;
      for (k = 1; k <= w + 4; k++) begin
         if (disturb)
            drive(w, int'($urandom), int'($urandom), int'($urandom_range(1)), k == 3);
         tick();
         if (outp(w, 1) == 32'd1) begin
            lat = k;
            break;
         end
      end
      drive(w, av, bv, bi, 1'b0);
      chk($sformatf("w%0d latency a=%0d b=%0d bin=%0d", w, av, bv, bi), lat, w);
      chk($sformatf("w%0d diff a=%0d b=%0d bin=%0d", w, av, bv, bi), outp(w, 2), ed);
      chk($sformatf("w%0d bout a=%0d b=%0d bin=%0d", w, av, bv, bi), outp(w, 3), eb);
      chk($sformatf("w%0d ovf a=%0d b=%0d bin=%0d", w, av, bv, bi), outp(w, 4), eo);
      tick();
      chk($sformatf("w%0d done_one_cycle", w), outp(w, 1), 0);
      chk($sformatf("w%0d busy_low_after", w), outp(w, 0), 0);
      chk($sformatf("w%0d diff_held_idle", w), outp(w, 2), ed);
      prev[w] = ed;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int ed, eb, eo, k, lat, ed2, eb2, eo2;
      n_err    = 0;
      n_checks = 0;
      for (int i = 0; i < 9; i++) prev[i] = 0;
      rst_n = 1'b0;
      drive(8, 0, 0, 0, 1'b0);
      drive(3, 0, 0, 0, 1'b0);
      drive(1, 0, 0, 0, 1'b0);
      tick();
      tick();
      for (int s = 0; s < 5; s++) begin
         chk($sformatf("reset_w8_out%0d", s), outp(8, s), 0);
         chk($sformatf("reset_w3_out%0d", s), outp(3, s), 0);
         chk($sformatf("reset_w1_out%0d", s), outp(1, s), 0);
      end
      rst_n = 1'b1;
      tick();

      // directed WIDTH=8 cases
      run_op(8, 100, 37, 0, 1'b0);
      run_op(8, 5, 9, 0, 1'b0);
      run_op(8, 0, 0, 1, 1'b0);
      run_op(8, 8'h80, 8'h01, 0, 1'b0);
      run_op(8, 8'h7F, 8'hFF, 0, 1'b0);

      // start re-asserted mid-RUN and operand bus churn: ignored
      run_op(8, 5, 9, 0, 1'b1);
      run_op(8, 200, 100, 1, 1'b1);

      // start held across DONE: back-to-back ops, WIDTH+2 cycles apart
      model(8, 200, 13, 1, ed, eb, eo);
      model(8, 3, 250, 0, ed2, eb2, eo2);
      drive(8, 200, 13, 1, 1'b1);
      tick();
      drive(8, 3, 250, 0, 1'b1);
      lat = -1;
      for (k = 1; k <= 12; k++) begin
         tick();
         if (done8) begin
            lat = k;
            break;
         end
      end
      chk("held_start first_latency", lat, 8);
      chk("held_start first_diff", outp(8, 2), ed);
      chk("held_start first_bout", outp(8, 3), eb);
      lat = -1;
      for (k = 1; k <= 14; k++) begin
         tick();
         if (k == 2) start8 = 1'b0;
         if (done8) begin
            lat = k;
            break;
         end
      end
      chk("held_start done_spacing", lat, 10);
      chk("held_start second_diff", outp(8, 2), ed2);
      chk("held_start second_bout", outp(8, 3), eb2);
      chk("held_start second_ovf", outp(8, 4), eo2);
      tick();
      chk("held_start idle_after", outp(8, 0), 0);
      prev[8] = ed2;

      // random WIDTH=8 traffic
      for (int i = 0; i < 24; i++)
         run_op(8, int'($urandom_range(255)), int'($urandom_range(255)),
                int'($urandom_range(1)), 1'b0);

      // exhaustive WIDTH=1 and WIDTH=3
      for (int x = 0; x < 2; x++)
         for (int y = 0; y < 2; y++)
            for (int z = 0; z < 2; z++)
               run_op(1, x, y, z, 1'b0);
      for (int x = 0; x < 8; x++)
         for (int y = 0; y < 8; y++)
            for (int z = 0; z < 2; z++)
               run_op(3, x, y, z, 1'b0);

      // asynchronous reset in the middle of RUN
      run_op(8, 250, 3, 0, 1'b0);
      drive(8, 17, 200, 1, 1'b1);
      tick();
      start8 = 1'b0;
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_reset busy", outp(8, 0), 0);
      chk("async_reset done", outp(8, 1), 0);
      chk("async_reset diff", outp(8, 2), 0);
      chk("async_reset bout", outp(8, 3), 0);
      chk("async_reset ovf", outp(8, 4), 0);
      chk("async_reset w3_diff", outp(3, 2), 0);
      rst_n = 1'b1;
      for (int i = 0; i < 9; i++) prev[i] = 0;
      tick();
      chk("after_reset still_idle", outp(8, 0), 0);
      run_op(8, 17, 200, 1, 1'b0);
      run_op(3, 6, 2, 1, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
